// File: rtl/mmio_arb_pkg.sv
// Shared types and widths for the two-master MMIO arbiter.
// The bus widths are also used by the MicroBlaze bridge and mmio_top.
package mmio_arb_pkg;

  localparam int MMIO_ADDR_W = 21;
  localparam int MMIO_DATA_W = 32;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    DONE  = 2'd2
  } state_e;

  typedef logic mst_idx_t;

  localparam mst_idx_t MST0 = 1'b0;
  localparam mst_idx_t MST1 = 1'b1;

  // The master that is not i.
  function automatic mst_idx_t other_mst(input mst_idx_t i);
    return ~i;
  endfunction

  // Request vector holding only master i.
  function automatic logic [1:0] mst_onehot(input mst_idx_t i);
    return (i == MST1) ? 2'b10 : 2'b01;
  endfunction

endpackage

// File: rtl/mmio_arbiter_rr_arb2.sv
// Two-way round-robin winner select with a registered priority pointer.
// With MMIO_ARB_LOCK_EN defined, a master that completes with its lock
// high keeps ownership: the pointer holds and only the owner may win the
// next arbitration, until it completes unlocked or idles its request.
module rr_arb2
  import mmio_arb_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic [1:0] req,
  input  logic       advance,
  input  mst_idx_t   done_idx,
`ifdef MMIO_ARB_LOCK_EN
  input  logic       sample,
  input  logic       done_lock,
`endif
  output logic       win_vld,
  output mst_idx_t   win_idx
);

  mst_idx_t   ptr_q, ptr_d;
  logic [1:0] req_eff;

`ifdef MMIO_ARB_LOCK_EN
  logic     owned_q, owned_d;
  mst_idx_t owner_q, owner_d;

  // Mask the competitor while owned; release when the owner idles or completes unlocked.
  always_comb begin
    req_eff = req;
    owned_d = owned_q;
    owner_d = owner_q;
    ptr_d   = ptr_q;
    if (sample && owned_q) begin
      if (req[owner_q]) begin
        req_eff = mst_onehot(owner_q);
      end else begin
        owned_d = 1'b0;
      end
    end
    if (advance) begin
      if (done_lock) begin
        owned_d = 1'b1;
        owner_d = done_idx;
      end else begin
        owned_d = 1'b0;
        ptr_d   = other_mst(done_idx);
      end
    end
  end

  // Pointer and ownership registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      ptr_q   <= MST0;
      owned_q <= 1'b0;
      owner_q <= MST0;
    end else begin
      ptr_q   <= ptr_d;
      owned_q <= owned_d;
      owner_q <= owner_d;
    end
  end
`else
  // Pointer moves past whichever master just completed.
  always_comb begin
    req_eff = req;
    ptr_d   = advance ? other_mst(done_idx) : ptr_q;
  end

  // Pointer register.
  always_ff @(posedge clk) begin
    if (reset) begin
      ptr_q <= MST0;
    end else begin
      ptr_q <= ptr_d;
    end
  end
`endif

  // Single requester wins outright; a tie goes to the pointer.
  always_comb begin
    win_vld = |req_eff;
    win_idx = MST0;
    case (req_eff)
      2'b01:   win_idx = MST0;
      2'b10:   win_idx = MST1;
      2'b11:   win_idx = ptr_q;
      default: win_idx = MST0;
    endcase
  end

endmodule

// File: rtl/mmio_arbiter.sv
// Two-master round-robin arbiter in front of mmio_top. Each grant makes
// one registered MMIO access (ISSUE) and one ack cycle (DONE) before the
// next arbitration. Optional macro MMIO_ARB_LOCK_EN adds m0_lock/m1_lock
// for back-to-back ownership of the bus.
module mmio_arbiter
  import mmio_arb_pkg::*;
#(
  parameter int ADDR_W = MMIO_ADDR_W,
  parameter int DATA_W = MMIO_DATA_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              m0_req,
  input  logic              m0_write,
  input  logic [ADDR_W-1:0] m0_addr,
  input  logic [DATA_W-1:0] m0_wdata,
  output logic [DATA_W-1:0] m0_rdata,
  output logic              m0_ack,
  input  logic              m1_req,
  input  logic              m1_write,
  input  logic [ADDR_W-1:0] m1_addr,
  input  logic [DATA_W-1:0] m1_wdata,
  output logic [DATA_W-1:0] m1_rdata,
  output logic              m1_ack,
`ifdef MMIO_ARB_LOCK_EN
  input  logic              m0_lock,
  input  logic              m1_lock,
`endif
  output logic              mmio_cs,
  output logic              mmio_write,
  output logic              mmio_read,
  output logic [ADDR_W-1:0] mmio_addr,
  output logic [DATA_W-1:0] mmio_write_data,
  input  logic [DATA_W-1:0] mmio_read_data,
  output logic              busy
);

  state_e            state_q, state_d;
  mst_idx_t          gnt_q, gnt_d;
  logic              cs_q, cs_d;
  logic              wr_q, wr_d;
  logic              rd_q, rd_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic              ack0_q, ack0_d;
  logic              ack1_q, ack1_d;
  logic [DATA_W-1:0] rdata0_q, rdata0_d;
  logic [DATA_W-1:0] rdata1_q, rdata1_d;
  logic              busy_q, busy_d;

  logic              win_vld;
  mst_idx_t          win_idx;

  rr_arb2 u_arb (
    .clk       (clk),
    .reset     (reset),
    .req       ({m1_req, m0_req}),
    .advance   (state_q == DONE),
    .done_idx  (gnt_q),
`ifdef MMIO_ARB_LOCK_EN
    .sample    (state_q == IDLE),
    .done_lock ((gnt_q == MST1) ? m1_lock : m0_lock),
`endif
    .win_vld   (win_vld),
    .win_idx   (win_idx)
  );

  // Next-state and next-output logic; bus strobes default low so they pulse for ISSUE only.
  always_comb begin
    state_d  = state_q;
    gnt_d    = gnt_q;
    cs_d     = 1'b0;
    wr_d     = 1'b0;
    rd_d     = 1'b0;
    addr_d   = '0;
    wdata_d  = '0;
    ack0_d   = 1'b0;
    ack1_d   = 1'b0;
    rdata0_d = rdata0_q;
    rdata1_d = rdata1_q;
    case (state_q)
      IDLE: begin
        if (win_vld) begin
          gnt_d   = win_idx;
          state_d = ISSUE;
          cs_d    = 1'b1;
          if (win_idx == MST1) begin
            wr_d    = m1_write;
            addr_d  = m1_addr;
            wdata_d = m1_wdata;
          end else begin
            wr_d    = m0_write;
            addr_d  = m0_addr;
            wdata_d = m0_wdata;
          end
          rd_d = ~wr_d;
        end
      end
      ISSUE: begin
        state_d = DONE;
        if (rd_q) begin
          if (gnt_q == MST1) rdata1_d = mmio_read_data;
          else               rdata0_d = mmio_read_data;
        end
        ack0_d = (gnt_q == MST0);
        ack1_d = (gnt_q == MST1);
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
    busy_d = (state_d != IDLE);
  end

  // State and registered outputs; reset aborts any access without an ack.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= IDLE;
      gnt_q    <= MST0;
      cs_q     <= 1'b0;
      wr_q     <= 1'b0;
      rd_q     <= 1'b0;
      addr_q   <= '0;
      wdata_q  <= '0;
      ack0_q   <= 1'b0;
      ack1_q   <= 1'b0;
      rdata0_q <= '0;
      rdata1_q <= '0;
      busy_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      gnt_q    <= gnt_d;
      cs_q     <= cs_d;
      wr_q     <= wr_d;
      rd_q     <= rd_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      ack0_q   <= ack0_d;
      ack1_q   <= ack1_d;
      rdata0_q <= rdata0_d;
      rdata1_q <= rdata1_d;
      busy_q   <= busy_d;
    end
  end

  assign mmio_cs         = cs_q;
  assign mmio_write      = wr_q;
  assign mmio_read       = rd_q;
  assign mmio_addr       = addr_q;
  assign mmio_write_data = wdata_q;
  assign m0_ack          = ack0_q;
  assign m1_ack          = ack1_q;
  assign m0_rdata        = rdata0_q;
  assign m1_rdata        = rdata1_q;
  assign busy            = busy_q;

endmodule

// File: tb/tb_mmio_arbiter.sv
// Bench for mmio_arbiter: directed scenarios with literal expectations
// plus randomized two-master traffic checked every cycle against a
// transaction-timing reference model.
module tb_mmio_arbiter;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        m0_req = 0, m0_write = 0, m1_req = 0, m1_write = 0;
  logic [20:0] m0_addr = '0, m1_addr = '0;
  logic [31:0] m0_wdata = '0, m1_wdata = '0, mmio_read_data = '0;
  logic        m0_lock = 1'b0, m1_lock = 1'b0;
  logic [31:0] m0_rdata, m1_rdata, mmio_write_data;
  logic [20:0] mmio_addr;
  logic        m0_ack, m1_ack, mmio_cs, mmio_write, mmio_read, busy;

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  mmio_arbiter dut (
    .clk             (clk),
    .reset           (rst),
    .m0_req          (m0_req),
    .m0_write        (m0_write),
    .m0_addr         (m0_addr),
    .m0_wdata        (m0_wdata),
    .m0_rdata        (m0_rdata),
    .m0_ack          (m0_ack),
    .m1_req          (m1_req),
    .m1_write        (m1_write),
    .m1_addr         (m1_addr),
    .m1_wdata        (m1_wdata),
    .m1_rdata        (m1_rdata),
    .m1_ack          (m1_ack),
`ifdef MMIO_ARB_LOCK_EN
    .m0_lock         (m0_lock),
    .m1_lock         (m1_lock),
`endif
    .mmio_cs         (mmio_cs),
    .mmio_write      (mmio_write),
    .mmio_read       (mmio_read),
    .mmio_addr       (mmio_addr),
    .mmio_write_data (mmio_write_data),
    .mmio_read_data  (mmio_read_data),
    .busy            (busy)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  // A grant decided in cycle g puts the access on the bus in g+1, acks in
  // g+2, and the master set is free to arbitrate again from g+3.
  int          cyc = 0;
  int          g_cyc = -100;
  int          d;
  bit          mv = 0;
  bit          g_idx, g_wr, m_ptr, m_owned, m_owner, win;
  logic [20:0] g_addr;
  logic [31:0] g_wdata;
  logic [31:0] m_rdata [2];
  int          wait0 = 0, wait1 = 0;

  always @(negedge clk) begin
    if (mv) begin
      d = cyc - g_cyc;
      chk("mdl_cs",    mmio_cs,         d == 1);
      chk("mdl_wr",    mmio_write,      (d == 1) && g_wr);
      chk("mdl_rd",    mmio_read,       (d == 1) && !g_wr);
      chk("mdl_addr",  mmio_addr,       (d == 1) ? g_addr : 21'd0);
      chk("mdl_wdata", mmio_write_data, (d == 1) ? g_wdata : 32'd0);
      chk("mdl_ack0",  m0_ack,          (d == 2) && !g_idx);
      chk("mdl_ack1",  m1_ack,          (d == 2) && g_idx);
      chk("mdl_busy",  busy,            (d == 1) || (d == 2));
      chk("mdl_rd0",   m0_rdata,        m_rdata[0]);
      chk("mdl_rd1",   m1_rdata,        m_rdata[1]);
      wait0 = (m0_req && !m0_ack) ? wait0 + 1 : 0;
      wait1 = (m1_req && !m1_ack) ? wait1 + 1 : 0;
      if (wait0 > 15 || wait1 > 15) begin
        chk("mdl_starve", 1, 0);
        wait0 = 0;
        wait1 = 0;
      end
    end
    if (rst) begin
      mv = 1;
      g_cyc = cyc - 100;
      m_ptr = 0;
      m_owned = 0;
      m_rdata[0] = '0;
      m_rdata[1] = '0;
      wait0 = 0;
      wait1 = 0;
    end else if (mv) begin
      d = cyc - g_cyc;
      if (d == 1 && !g_wr) m_rdata[g_idx] = mmio_read_data;
      if (d == 2) begin
        if (g_idx ? m1_lock : m0_lock) begin
          m_owned = 1;
          m_owner = g_idx;
        end else begin
          m_owned = 0;
          m_ptr = !g_idx;
        end
      end
      if (d >= 3 && (m0_req || m1_req)) begin
        if (m_owned && (m_owner ? m1_req : m0_req)) win = m_owner;
        else begin
          m_owned = 0;
          win = (m0_req && m1_req) ? m_ptr : m1_req;
        end
        if (m_owned || m0_req || m1_req) begin
          g_cyc = cyc;
          g_idx = win;
          g_wr = win ? m1_write : m0_write;
          g_addr = win ? m1_addr : m0_addr;
          g_wdata = win ? m1_wdata : m0_wdata;
        end
      end
    end
    cyc++;
  end

  // ---------------- stimulus ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1; m0_req = 0; m1_req = 0;
    tick(); tick();
    rst = 0;
  endtask

  // Wait (bounded) for master m's ack, then drop its request.
  task automatic wait_ack_drop(input bit m);
    bit got = 0;
    for (int k = 0; k < 12 && !got; k++) begin
      @(negedge clk);
      got = m ? m1_ack : m0_ack;
      tick();
    end
    chk(m ? "ack1_timeout" : "ack0_timeout", got, 1);
    if (m) m1_req = 0; else m0_req = 0;
  endtask

  logic [20:0] seq_addr [8];
  int          seq_cyc [8];
  int          nseq, c0, c1;
  bit          a0, a1;

  initial begin
    m_rdata[0] = '0;
    m_rdata[1] = '0;
    tick(); tick();
    @(negedge clk);
    chk("rst_busy", busy, 0);
    chk("rst_cs", mmio_cs, 0);
    chk("rst_rdata0", m0_rdata, 0);
    rst = 0;

    // m0 reads 0x4
    tick();
    m0_req = 1; m0_write = 0; m0_addr = 21'h4; mmio_read_data = 32'hDEADBEEF;
    @(negedge clk); chk("t1_cs_early", mmio_cs, 0);
    tick();
    @(negedge clk);
    chk("t1_cs", mmio_cs, 1); chk("t1_read", mmio_read, 1);
    chk("t1_write", mmio_write, 0); chk("t1_addr", mmio_addr, 21'h4);
    tick();
    @(negedge clk);
    chk("t1_ack0", m0_ack, 1); chk("t1_rdata0", m0_rdata, 32'hDEADBEEF);
    chk("t1_ack1", m1_ack, 0); chk("t1_cs_off", mmio_cs, 0);
    tick();
    m0_req = 0;
    @(negedge clk); chk("t1_busy_off", busy, 0);

    // m1 writes 0xF to 0x10
    tick();
    m1_req = 1; m1_write = 1; m1_addr = 21'h10; m1_wdata = 32'hF;
    tick();
    @(negedge clk);
    chk("t2_cs", mmio_cs, 1); chk("t2_write", mmio_write, 1);
    chk("t2_read", mmio_read, 0); chk("t2_wdata", mmio_write_data, 32'hF);
    chk("t2_addr", mmio_addr, 21'h10);
    tick();
    @(negedge clk);
    chk("t2_ack1", m1_ack, 1); chk("t2_cs_pulse", mmio_cs, 0);
    chk("t2_rdata1", m1_rdata, 0); chk("t2_rdata0_kept", m0_rdata, 32'hDEADBEEF);
    tick();
    m1_req = 0;

    // Contention after reset: m0,m1,m0,m1 with 3-cycle spacing
    do_reset();
    m0_req = 1; m0_write = 0; m0_addr = 21'h100;
    m1_req = 1; m1_write = 0; m1_addr = 21'h200;
    nseq = 0; c0 = 0; c1 = 0;
    for (int k = 0; k < 30 && !(c0 >= 2 && c1 >= 2); k++) begin
      @(negedge clk);
      if (mmio_cs && nseq < 8) begin
        seq_addr[nseq] = mmio_addr; seq_cyc[nseq] = k; nseq++;
      end
      if (m0_ack) c0++;
      if (m1_ack) c1++;
      tick();
      if (c0 >= 2) m0_req = 0;
      if (c1 >= 2) m1_req = 0;
    end
    chk("t3_count", nseq, 4);
    chk("t3_g0", seq_addr[0], 21'h100); chk("t3_g1", seq_addr[1], 21'h200);
    chk("t3_g2", seq_addr[2], 21'h100); chk("t3_g3", seq_addr[3], 21'h200);
    chk("t3_gap1", seq_cyc[1] - seq_cyc[0], 3);
    chk("t3_gap3", seq_cyc[3] - seq_cyc[2], 3);

    // m0 arrives during m1's ISSUE and changes its address before its grant
    tick();
    m1_req = 1; m1_write = 0; m1_addr = 21'h40;
    tick();
    m0_req = 1; m0_write = 1; m0_addr = 21'h111; m0_wdata = 32'hAAAA;
    tick();
    m0_addr = 21'h222; m0_wdata = 32'hBBBB;
    @(negedge clk); chk("t4_ack1", m1_ack, 1);
    tick();
    m1_req = 0;
    @(negedge clk); chk("t4_idle_cs", mmio_cs, 0);
    tick();
    @(negedge clk);
    chk("t4_cs", mmio_cs, 1); chk("t4_addr", mmio_addr, 21'h222);
    chk("t4_wdata", mmio_write_data, 32'hBBBB);
    tick();
    @(negedge clk); chk("t4_ack0", m0_ack, 1);
    tick();
    m0_req = 0;

    // Reset during ISSUE, pointer returns to m0 (m0 was last served)
    tick();
    m1_req = 1; m1_write = 0; m1_addr = 21'h55;
    tick();
    rst = 1; m1_req = 0;
    @(negedge clk); chk("t5_cs_issue", mmio_cs, 1);
    tick();
    rst = 0;
    m0_req = 1; m0_write = 0; m0_addr = 21'h66;
    m1_req = 1; m1_write = 0; m1_addr = 21'h77;
    @(negedge clk);
    chk("t5_cs", mmio_cs, 0); chk("t5_ack1", m1_ack, 0);
    chk("t5_busy", busy, 0); chk("t5_rdata1", m1_rdata, 0);
    tick();
    @(negedge clk);
    chk("t5_ptr_m0", mmio_addr, 21'h66);
    wait_ack_drop(0);
    wait_ack_drop(1);

    // Randomized traffic with occasional resets
    for (int n = 0; n < 1500; n++) begin
      @(negedge clk); a0 = m0_ack; a1 = m1_ack;
      tick();
      mmio_read_data = $urandom;
      if (rst) rst = 0;
      else if ($urandom_range(0, 149) == 0) begin
        rst = 1; m0_req = 0; m1_req = 0;
        continue;
      end
      if (m0_req) begin
        if (a0) m0_req = $urandom_range(0, 1);
        if (a0 && m0_req) begin
          m0_write = $urandom_range(0, 1); m0_addr = 21'($urandom); m0_wdata = $urandom;
        end
      end else if ($urandom_range(0, 2) == 0) begin
        m0_req = 1; m0_write = $urandom_range(0, 1); m0_addr = 21'($urandom); m0_wdata = $urandom;
      end
      if (m1_req) begin
        if (a1) m1_req = $urandom_range(0, 1);
        if (a1 && m1_req) begin
          m1_write = $urandom_range(0, 1); m1_addr = 21'($urandom); m1_wdata = $urandom;
        end
      end else if ($urandom_range(0, 2) == 0) begin
        m1_req = 1; m1_write = $urandom_range(0, 1); m1_addr = 21'($urandom); m1_wdata = $urandom;
      end
    end

`ifdef MMIO_ARB_LOCK_EN
    // m0 keeps ownership for three transactions while m1 waits
    do_reset();
    m0_req = 1; m0_lock = 1; m0_write = 0; m0_addr = 21'h100;
    m1_req = 1; m1_write = 0; m1_addr = 21'h300;
    nseq = 0; c0 = 0; c1 = 0;
    for (int k = 0; k < 40 && c1 < 1; k++) begin
      @(negedge clk);
      if (mmio_cs && nseq < 8) begin
        seq_addr[nseq] = mmio_addr; nseq++;
      end
      if (m0_ack) c0++;
      if (m1_ack) c1++;
      tick();
      if (c0 >= 2) m0_lock = 0;
    end
    m0_req = 0; m1_req = 0;
    chk("lk_count", nseq, 4);
    chk("lk_g0", seq_addr[0], 21'h100); chk("lk_g1", seq_addr[1], 21'h100);
    chk("lk_g2", seq_addr[2], 21'h100); chk("lk_g3", seq_addr[3], 21'h300);
`endif

    m0_req = 0; m1_req = 0; rst = 0;
    repeat (5) tick();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
